// File: rtl/hwgen_ifg_hdr_gen_pkg.sv
// Shared types and helpers for the hwgen v2 header generator: header layout,
// FSM encoding, magic number and the fixed-point cycles-per-ns conversion.
package hwgen_ifg_hdr_gen_pkg;

  localparam logic [15:0] HWGEN_MAGIC_NUMBER_C = 16'h6969;

  typedef struct packed {
    logic [31:0] ifg;
    logic [15:0] orig_len;
    logic [15:0] magic;
  } hwgen_hdr_v2_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCALE = 2'd1,
    ST_MUL   = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  // round(2^frac * freq / 1e9); the +5e8 turns the integer division into rounding
  function automatic longint unsigned cyc_per_ns_q(input longint unsigned freq,
                                                   input int unsigned     frac);
    return ((freq << frac) + 64'd500_000_000) / 64'd1_000_000_000;
  endfunction

  function automatic bit out_width_ok(input int unsigned w);
    return (w == 32) || (w == 64) || (w == 128);
  endfunction

endpackage

// File: rtl/hwgen_ifg_hdr_gen_ser.sv
// AXI4-Stream serializer for one 64-bit hwgen v2 header: a single beat for
// 64/128-bit buses, two beats ({len, magic} then ifg) for a 32-bit bus.
module hwgen_axis_hdr_ser
  import hwgen_ifg_hdr_gen_pkg::*;
#(
  parameter int OUT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  hwgen_hdr_v2_t          i_hdr,
  input  logic                   i_tready,
  output logic                   o_tvalid,
  output logic [OUT_WIDTH-1:0]   o_tdata,
  output logic [OUT_WIDTH/8-1:0] o_tstrb,
  output logic                   o_tlast,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int SW = OUT_WIDTH / 8;
  // Only the low 8 byte lanes ever carry header bytes (128-bit bus: upper half zero)
  localparam logic [SW-1:0] STRB_C = SW'(8'hFF);

  logic                 r_tvalid;
  logic                 r_tlast;
  logic [OUT_WIDTH-1:0] r_tdata;
  logic [SW-1:0]        r_tstrb;
  logic [31:0]          r_ifg_hold;
  logic                 w_hs;

  assign w_hs = r_tvalid & i_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tdata    <= '0;
      r_tstrb    <= '0;
      r_ifg_hold <= '0;
    end else if (i_load) begin
      r_tvalid   <= 1'b1;
      r_tstrb    <= STRB_C;
      r_ifg_hold <= i_hdr.ifg;
      if (OUT_WIDTH == 32) begin
        r_tdata <= OUT_WIDTH'({i_hdr.orig_len, i_hdr.magic});
        r_tlast <= 1'b0;
      end else begin
        r_tdata <= OUT_WIDTH'(i_hdr);
        r_tlast <= 1'b1;
      end
    end else if (w_hs) begin
      if (r_tlast) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_tdata  <= '0;
        r_tstrb  <= '0;
      end else begin
        r_tdata <= OUT_WIDTH'(r_ifg_hold);
        r_tlast <= 1'b1;
      end
    end
  end

  assign o_tvalid = r_tvalid;
  assign o_tdata  = r_tdata;
  assign o_tstrb  = r_tstrb;
  assign o_tlast  = r_tlast;
  assign o_busy   = r_tvalid;
  assign o_done   = w_hs & r_tlast;

endmodule

// File: rtl/hwgen_ifg_hdr_gen.sv
// Turns pcap record headers into hwgen v2 headers: timestamp delta -> IFG in
// tx-clock cycles (fixed point, saturating), length clamp, AXIS output.
module hwgen_ifg_hdr_gen
  import hwgen_ifg_hdr_gen_pkg::*;
#(
  parameter int              OUT_WIDTH      = 64,
  parameter longint unsigned CLOCK_FREQ_HZ  = 64'd156_250_000,
  parameter int              FRAC_BITS      = 16,
  parameter logic [31:0]     MIN_IFG_CYCLES = 32'd0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_ts_is_us,
  input  logic                   cfg_restart,
  input  logic                   rec_valid,
  output logic                   rec_ready,
  input  logic [63:0]            rec_ts,
  input  logic [31:0]            rec_orig_len,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [OUT_WIDTH/8-1:0] m_axis_tstrb,
  output logic                   m_axis_tlast,
  output logic [31:0]            stat_rec_cnt,
  output logic [15:0]            stat_sat_cnt,
  output logic [15:0]            stat_nonmono_cnt,
  output state_t                 dbg_state
);

  localparam longint unsigned CYC_PER_NS_Q = cyc_per_ns_q(CLOCK_FREQ_HZ, FRAC_BITS);

  if (!out_width_ok(OUT_WIDTH)) begin : g_bad_width
    $fatal(1, "hwgen_ifg_hdr_gen: OUT_WIDTH must be 32, 64 or 128");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never depends on ready and, once raised, holds with stable data until taken.
  state_t        r_state, w_state_nxt;
  logic          r_alive;
  logic [63:0]   r_ts, r_prev_ns, r_delta;
  logic [31:0]   r_len;
  logic          r_is_us, r_first, r_is_first;
  logic [31:0]   r_rec_cnt;
  logic [15:0]   r_sat_cnt, r_nonmono_cnt;
  logic          w_rec_ready, w_ser_load, w_ser_done, w_ser_busy;
  logic [63:0]   w_ts_ns;
  logic [47:0]   w_d48;
  logic [79:0]   w_prod, w_cyc;
  logic          w_ifg_sat, w_len_sat;
  logic [31:0]   w_ifg_raw, w_ifg;
  logic [15:0]   w_len16;
  hwgen_hdr_v2_t w_hdr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rec_ready = 1'b0;
    w_ser_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rec_ready = r_alive;
        if (rec_valid && r_alive) w_state_nxt = ST_SCALE;
      end
      ST_SCALE: w_state_nxt = ST_MUL;
      ST_MUL: begin
        w_ser_load  = 1'b1;
        w_state_nxt = ST_EMIT;
      end
      ST_EMIT:  if (w_ser_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Deltas of 2^48 ns and beyond are already far past the 32-bit IFG range
  assign w_ts_ns   = r_is_us ? (r_ts * 64'd1000) : r_ts;
  assign w_d48     = (|r_delta[63:48]) ? 48'hFFFF_FFFF_FFFF : r_delta[47:0];
  assign w_prod    = {32'd0, w_d48} * 80'(CYC_PER_NS_Q);
  assign w_cyc     = w_prod >> FRAC_BITS;
  assign w_ifg_sat = |w_cyc[79:32];
  assign w_ifg_raw = w_ifg_sat ? 32'hFFFF_FFFF : w_cyc[31:0];
  assign w_ifg     = r_is_first ? 32'd0
                   : ((w_ifg_raw < MIN_IFG_CYCLES) ? MIN_IFG_CYCLES : w_ifg_raw);
  assign w_len_sat = r_len > 32'd65535;
  assign w_len16   = w_len_sat ? 16'hFFFF : r_len[15:0];

  always_comb begin
    w_hdr          = '0;
    w_hdr.ifg      = w_ifg;
    w_hdr.orig_len = w_len16;
    w_hdr.magic    = HWGEN_MAGIC_NUMBER_C;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive       <= 1'b0;
      r_ts          <= '0;
      r_len         <= '0;
      r_is_us       <= 1'b0;
      r_prev_ns     <= '0;
      r_delta       <= '0;
      r_first       <= 1'b1;
      r_is_first    <= 1'b0;
      r_rec_cnt     <= '0;
      r_sat_cnt     <= '0;
      r_nonmono_cnt <= '0;
    end else begin
      r_alive <= 1'b1;
      if (r_state == ST_IDLE && rec_valid && w_rec_ready) begin
        r_ts    <= rec_ts;
        r_len   <= rec_orig_len;
        r_is_us <= cfg_ts_is_us;
      end
      if (r_state == ST_SCALE) begin
        r_is_first <= r_first;
        if (r_first) begin
          r_delta   <= '0;
          r_prev_ns <= w_ts_ns;
        end else if (w_ts_ns < r_prev_ns) begin
          r_delta       <= '0;
          r_nonmono_cnt <= r_nonmono_cnt + 16'd1;
        end else begin
          r_delta   <= w_ts_ns - r_prev_ns;
          r_prev_ns <= w_ts_ns;
        end
      end
      if (r_state == ST_MUL && ((w_ifg_sat && !r_is_first) || w_len_sat))
        r_sat_cnt <= r_sat_cnt + 16'd1;
      // A restart always wins over the first-record clear so it is never lost
      if (cfg_restart)                      r_first <= 1'b1;
      else if (r_state == ST_MUL && r_is_first) r_first <= 1'b0;
      if (r_state == ST_EMIT && w_ser_done)
        r_rec_cnt <= r_rec_cnt + 32'd1;
    end
  end

  hwgen_axis_hdr_ser #(.OUT_WIDTH(OUT_WIDTH)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_ser_load),
    .i_hdr    (w_hdr),
    .i_tready (m_axis_tready),
    .o_tvalid (m_axis_tvalid),
    .o_tdata  (m_axis_tdata),
    .o_tstrb  (m_axis_tstrb),
    .o_tlast  (m_axis_tlast),
    .o_busy   (w_ser_busy),
    .o_done   (w_ser_done)
  );

  assign rec_ready        = w_rec_ready & ~w_ser_busy;
  assign stat_rec_cnt     = r_rec_cnt;
  assign stat_sat_cnt     = r_sat_cnt;
  assign stat_nonmono_cnt = r_nonmono_cnt;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_hwgen_ifg_hdr_gen.sv
// Bench for hwgen_ifg_hdr_gen: a 64-bit instance driven from a vector table and
// a 32-bit instance under toggling backpressure and a mid-header reset.
module tb_hwgen_ifg_hdr_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // instance A: OUT_WIDTH = 64
  logic        rst_n_a, restart_a, us_a, rec_valid_a, rec_ready_a;
  logic        tvalid_a, tready_a, tlast_a;
  logic [63:0] rec_ts_a, tdata_a;
  logic [31:0] rec_len_a, rec_cnt_a;
  logic [7:0]  tstrb_a;
  logic [15:0] sat_cnt_a, nonmono_cnt_a;
  logic [1:0]  dbg_a;

  // instance B: OUT_WIDTH = 32
  logic        rst_n_b, restart_b, us_b, rec_valid_b, rec_ready_b;
  logic        tvalid_b, tready_b, tlast_b, tog_b;
  logic [63:0] rec_ts_b;
  logic [31:0] rec_len_b, rec_cnt_b, tdata_b;
  logic [3:0]  tstrb_b;
  logic [15:0] sat_cnt_b, nonmono_cnt_b;
  logic [1:0]  dbg_b;

  hwgen_ifg_hdr_gen #(.OUT_WIDTH(64)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .cfg_ts_is_us(us_a), .cfg_restart(restart_a),
    .rec_valid(rec_valid_a), .rec_ready(rec_ready_a), .rec_ts(rec_ts_a),
    .rec_orig_len(rec_len_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
    .m_axis_tdata(tdata_a), .m_axis_tstrb(tstrb_a), .m_axis_tlast(tlast_a),
    .stat_rec_cnt(rec_cnt_a), .stat_sat_cnt(sat_cnt_a),
    .stat_nonmono_cnt(nonmono_cnt_a), .dbg_state(dbg_a)
  );

  hwgen_ifg_hdr_gen #(.OUT_WIDTH(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .cfg_ts_is_us(us_b), .cfg_restart(restart_b),
    .rec_valid(rec_valid_b), .rec_ready(rec_ready_b), .rec_ts(rec_ts_b),
    .rec_orig_len(rec_len_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
    .m_axis_tdata(tdata_b), .m_axis_tstrb(tstrb_b), .m_axis_tlast(tlast_b),
    .stat_rec_cnt(rec_cnt_b), .stat_sat_cnt(sat_cnt_b),
    .stat_nonmono_cnt(nonmono_cnt_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q_a[$];
  logic [32:0] exp_q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n_a && tvalid_a && tready_a) begin
      if (exp_q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_beat_a: got %h expected no beat", tdata_a);
      end else begin
        check("hdr_a", tdata_a, exp_q_a.pop_front());
        check("tlast_a", {63'd0, tlast_a}, 64'd1);
        check("tstrb_a", {56'd0, tstrb_a}, 64'hFF);
      end
    end
  end

  logic [32:0] prev_beat_b;
  logic        prev_stall_b = 1'b0;
  always @(negedge clk) begin
    if (!rst_n_b || !tvalid_b) begin
      prev_stall_b = 1'b0;
    end else begin
      check("rec_ready_low_b", {63'd0, rec_ready_b}, 64'd0);
      check("tstrb_b", {60'd0, tstrb_b}, 64'hF);
      if (prev_stall_b) check("stable_b", {31'd0, tlast_b, tdata_b}, {31'd0, prev_beat_b});
      if (tready_b) begin
        prev_stall_b = 1'b0;
        if (exp_q_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat_b: got %h expected no beat", tdata_b);
        end else begin
          check("beat_b", {31'd0, tlast_b, tdata_b}, {31'd0, exp_q_b.pop_front()});
        end
      end else begin
        prev_stall_b = 1'b1;
        prev_beat_b  = {tlast_b, tdata_b};
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tog_b) tready_b = ~tready_b;
    end
  end

  task automatic drive_a(input logic [63:0] ts, input logic [31:0] len, input logic us);
    int n;
    rec_ts_a = ts; rec_len_a = len; us_a = us; rec_valid_a = 1'b1; n = 0;
    @(negedge clk);
    while (!rec_ready_a && n < 200) begin @(negedge clk); n++; end
    if (!rec_ready_a) check("accept_timeout_a", {63'd0, rec_ready_a}, 64'd1);
    @(posedge clk); #1 rec_valid_a = 1'b0;
  endtask

  task automatic drive_b(input logic [63:0] ts, input logic [31:0] len, input logic us);
    int n;
    rec_ts_b = ts; rec_len_b = len; us_b = us; rec_valid_b = 1'b1; n = 0;
    @(negedge clk);
    while (!rec_ready_b && n < 200) begin @(negedge clk); n++; end
    if (!rec_ready_b) check("accept_timeout_b", {63'd0, rec_ready_b}, 64'd1);
    @(posedge clk); #1 rec_valid_b = 1'b0;
  endtask

  task automatic wait_empty_a();
    int n = 0;
    while (exp_q_a.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    if (exp_q_a.size() != 0) check("drain_timeout_a", 64'(exp_q_a.size()), 64'd0);
  endtask

  task automatic wait_empty_b();
    int n = 0;
    while (exp_q_b.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    if (exp_q_b.size() != 0) check("drain_timeout_b", 64'(exp_q_b.size()), 64'd0);
  endtask

  task automatic restart_pulse_a();
    wait_empty_a();
    @(posedge clk); #1 restart_a = 1'b1;
    @(posedge clk); #1 restart_a = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] ifg, input logic [15:0] len16);
    exp_q_b.push_back({1'b0, len16, 16'h6969});
    exp_q_b.push_back({1'b1, ifg});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        restart;
    logic        us;
    logic [63:0] ts;
    logic [31:0] len;
    logic [31:0] ifg;
    logic [15:0] len16;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{restart:1'b1, us:1'b0, ts:64'd1000,               len:32'd60,    ifg:32'd0,          len16:16'd60};
    vt[1]  = '{restart:1'b0, us:1'b0, ts:64'd1640,               len:32'd100,   ifg:32'd100,        len16:16'd100};
    vt[2]  = '{restart:1'b1, us:1'b1, ts:64'd5,                  len:32'd1514,  ifg:32'd0,          len16:16'h05EA};
    vt[3]  = '{restart:1'b0, us:1'b1, ts:64'd7,                  len:32'd1514,  ifg:32'd312,        len16:16'h05EA};
    vt[4]  = '{restart:1'b1, us:1'b0, ts:64'd0,                  len:32'd64,    ifg:32'd0,          len16:16'd64};
    vt[5]  = '{restart:1'b0, us:1'b0, ts:64'h100_0000_0000,      len:32'd64,    ifg:32'hFFFF_FFFF,  len16:16'd64};
    vt[6]  = '{restart:1'b0, us:1'b0, ts:64'h100_0000_0280,      len:32'd70000, ifg:32'd100,        len16:16'hFFFF};
    vt[7]  = '{restart:1'b1, us:1'b0, ts:64'd2000,               len:32'd64,    ifg:32'd0,          len16:16'd64};
    vt[8]  = '{restart:1'b0, us:1'b0, ts:64'd1500,               len:32'd64,    ifg:32'd0,          len16:16'd64};
    vt[9]  = '{restart:1'b0, us:1'b0, ts:64'd2640,               len:32'd64,    ifg:32'd100,        len16:16'd64};
    vt[10] = '{restart:1'b0, us:1'b0, ts:64'd9040,               len:32'd65535, ifg:32'd1000,       len16:16'hFFFF};
    vt[11] = '{restart:1'b0, us:1'b0, ts:64'h0004_0000_0000_2350, len:32'd64,   ifg:32'hFFFF_FFFF,  len16:16'd64};
    vt[12] = '{restart:1'b0, us:1'b0, ts:64'h0004_0000_0000_2353, len:32'd64,   ifg:32'd0,          len16:16'd64};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n_a = 1'b0; restart_a = 1'b0; us_a = 1'b0; rec_valid_a = 1'b0;
    rec_ts_a = '0; rec_len_a = '0; tready_a = 1'b1;
    rst_n_b = 1'b0; restart_b = 1'b0; us_b = 1'b0; rec_valid_b = 1'b0;
    rec_ts_b = '0; rec_len_b = '0; tready_b = 1'b1; tog_b = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rec_ready_a", {63'd0, rec_ready_a}, 64'd0);
    check("rst_tvalid_a",    {63'd0, tvalid_a}, 64'd0);
    check("rst_tdata_a",     tdata_a, 64'd0);
    check("rst_tstrb_tlast_a", {55'd0, tstrb_a, tlast_a}, 64'd0);
    check("rst_stats_a",     {rec_cnt_a, sat_cnt_a, nonmono_cnt_a}, 64'd0);
    check("rst_state_a",     {62'd0, dbg_a}, 64'd0);
    check("rst_rec_ready_b", {63'd0, rec_ready_b}, 64'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_rec_ready_a", {63'd0, rec_ready_a}, 64'd1);
    check("idle_rec_ready_b", {63'd0, rec_ready_b}, 64'd1);

    // table-driven records on the 64-bit instance
    for (int i = 0; i < 13; i++) begin
      if (vt[i].restart) restart_pulse_a();
      exp_q_a.push_back({vt[i].ifg, vt[i].len16, 16'h6969});
      drive_a(vt[i].ts, vt[i].len, vt[i].us);
    end

    // accept -> first tvalid three cycles later
    wait_empty_a();
    exp_q_a.push_back({32'd100, 16'd64, 16'h6969});
    drive_a(64'h0004_0000_0000_25D3, 32'd64, 1'b0);
    @(posedge clk); #1;
    check("latency_t2_a", {63'd0, tvalid_a}, 64'd0);
    @(posedge clk); #1;
    check("latency_t3_a", {63'd0, tvalid_a}, 64'd1);
    wait_empty_a();
    repeat (2) @(posedge clk);
    #1;
    check("rec_cnt_a",     64'(rec_cnt_a), 64'd14);
    check("sat_cnt_a",     64'(sat_cnt_a), 64'd3);
    check("nonmono_cnt_a", 64'(nonmono_cnt_a), 64'd1);

    // 32-bit instance: two beats per header, tready toggling every cycle
    tog_b = 1'b1;
    push_b(32'd0, 16'd60);
    drive_b(64'd1000, 32'd60, 1'b0);
    push_b(32'd100, 16'h05EA);
    drive_b(64'd1640, 32'd1514, 1'b0);
    push_b(32'd2000, 16'hFFFF);
    drive_b(64'd14440, 32'd70000, 1'b0);
    wait_empty_b();
    repeat (2) @(posedge clk);
    #1;
    check("rec_cnt_b", 64'(rec_cnt_b), 64'd3);
    check("sat_cnt_b", 64'(sat_cnt_b), 64'd1);

    // reset while a 32-bit header is stalled mid-EMIT
    tog_b = 1'b0;
    @(posedge clk); #1 tready_b = 1'b0;
    drive_b(64'd20000, 32'd64, 1'b0);
    @(posedge clk); #1;
    check("latency_t2_b", {63'd0, tvalid_b}, 64'd0);
    @(posedge clk); #1;
    check("latency_t3_b", {63'd0, tvalid_b}, 64'd1);
    repeat (2) @(posedge clk);
    #2 rst_n_b = 1'b0;
    #1;
    check("midrst_tvalid_b", {63'd0, tvalid_b}, 64'd0);
    check("midrst_tdata_b",  {31'd0, tlast_b, tdata_b}, 64'd0);
    check("midrst_ready_b",  {63'd0, rec_ready_b}, 64'd0);
    check("midrst_stats_b",  {rec_cnt_b, sat_cnt_b, nonmono_cnt_b}, 64'd0);
    @(posedge clk); #1 rst_n_b = 1'b1; tready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_tvalid_b", {63'd0, tvalid_b}, 64'd0);
    check("post_rst_ready_b",  {63'd0, rec_ready_b}, 64'd1);
    tog_b = 1'b1;
    push_b(32'd0, 16'd64);
    drive_b(64'd500, 32'd64, 1'b0);
    wait_empty_b();
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_rec_cnt_b", 64'(rec_cnt_b), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
